// File: rtl/fib_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : fib_dispatch
// Purpose  : Queues Fibonacci requests in a small FIFO and dispatches them
//            one at a time to a downstream fib engine. Each engine result is
//            returned in request order through a valid/ready response port.
//            out_overflow reports only overflow newly raised by this job,
//            because the engine's overflow flag is sticky.
// Ports    : clk, rst (async, active-high)
//            in_valid/in_ready/in_n                 - request port
//            out_valid/out_ready/out_n/out_result/
//            out_overflow                           - response port
//            fib_go/fib_n                           - engine command
//            fib_result/fib_overflow/fib_done       - engine status
//            job_count[15:0]                        - completed-response
//                                                     counter, only when
//                                                     FIB_DISPATCH_COUNT_EN
//                                                     is defined
// Options  : `define FIB_DISPATCH_COUNT_EN adds job_count.
// Revision : 1.0 - initial release
// ============================================================================
module fib_dispatch #(
  parameter int INPUT_WIDTH  = 6,
  parameter int OUTPUT_WIDTH = 64,
  parameter int DEPTH        = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INPUT_WIDTH-1:0]  in_n,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [INPUT_WIDTH-1:0]  out_n,
  output logic [OUTPUT_WIDTH-1:0] out_result,
  output logic                    out_overflow,
  output logic                    fib_go,
  output logic [INPUT_WIDTH-1:0]  fib_n,
  input  logic [OUTPUT_WIDTH-1:0] fib_result,
  input  logic                    fib_overflow,
  input  logic                    fib_done
`ifdef FIB_DISPATCH_COUNT_EN
  ,
  output logic [15:0]             job_count
`endif
);

  localparam int c_addr_w = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_CLR  = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_t;

  state_t r_state, w_state_nxt;

  // --------------------------------------------------------------------------
  // Request FIFO. Pointers carry one extra MSB so that full and empty can be
  // told apart when the low address bits match.
  // --------------------------------------------------------------------------
  logic [INPUT_WIDTH-1:0] r_mem [DEPTH];
  logic [c_addr_w:0]      r_wr_ptr;
  logic [c_addr_w:0]      r_rd_ptr;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;

  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                    (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);
  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_addr_w-1:0]] <= in_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM. The FIFO head is moved into the hold register on the edge
  // that enters ISSUE, so fib_n is already valid while fib_go is high.
  // --------------------------------------------------------------------------
  logic w_go;
  logic w_capture;
  logic w_resp_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_go        = 1'b0;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    w_resp_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        w_go        = 1'b1;
        w_state_nxt = WAIT_CLR;
      end
      WAIT_CLR: begin
        // done may still be high from the previous job; wait for it to drop.
        if (!fib_done) w_state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (fib_done) begin
          w_capture   = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (out_ready) begin
          w_resp_done = 1'b1;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = ISSUE;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign fib_go = w_go;

  // --------------------------------------------------------------------------
  // Datapath: hold register, overflow baseline and response registers.
  // --------------------------------------------------------------------------
  logic [INPUT_WIDTH-1:0]  r_n_hold;
  logic                    r_ovf_base;
  logic                    r_out_valid;
  logic [INPUT_WIDTH-1:0]  r_out_n;
  logic [OUTPUT_WIDTH-1:0] r_out_result;
  logic                    r_out_overflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n_hold       <= '0;
      r_ovf_base     <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_n        <= '0;
      r_out_result   <= '0;
      r_out_overflow <= 1'b0;
    end else begin
      if (w_pop) r_n_hold <= r_mem[r_rd_ptr[c_addr_w-1:0]];
      // Snapshot the sticky engine flag at issue; only a 0->1 change during
      // this job counts as this job's overflow.
      if (w_go)  r_ovf_base <= fib_overflow;
      if (w_capture) begin
        r_out_valid    <= 1'b1;
        r_out_n        <= r_n_hold;
        r_out_result   <= fib_result;
        r_out_overflow <= fib_overflow && !r_ovf_base;
      end else if (w_resp_done) begin
        r_out_valid    <= 1'b0;
      end
    end
  end

  assign fib_n        = r_n_hold;
  assign out_valid    = r_out_valid;
  assign out_n        = r_out_n;
  assign out_result   = r_out_result;
  assign out_overflow = r_out_overflow;

`ifdef FIB_DISPATCH_COUNT_EN
  logic [15:0] r_job_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_job_count <= '0;
    else if (out_valid && out_ready) r_job_count <= r_job_count + 16'd1;
  end

  assign job_count = r_job_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fib_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_fib_dispatch
// Purpose  : Self-checking bench for fib_dispatch with a behavioural fib
//            engine and a queue-based reference model of the response stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fib_dispatch;
  localparam int IW    = 6;
  localparam int OW    = 64;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_n = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [IW-1:0] out_n;
  logic [OW-1:0] out_result;
  logic          out_overflow;
  logic          fib_go;
  logic [IW-1:0] fib_n;
  logic [OW-1:0] fib_result;
  logic          fib_overflow;
  logic          fib_done;
`ifdef FIB_DISPATCH_COUNT_EN
  logic [15:0]   job_count;
`endif

  always #5 clk = ~clk;

  fib_dispatch #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_n(in_n),
    .out_valid(out_valid), .out_ready(out_ready), .out_n(out_n),
    .out_result(out_result), .out_overflow(out_overflow),
    .fib_go(fib_go), .fib_n(fib_n), .fib_result(fib_result),
    .fib_overflow(fib_overflow), .fib_done(fib_done)
`ifdef FIB_DISPATCH_COUNT_EN
    , .job_count(job_count)
`endif
  );

  // ---------------- helpers ----------------
  function automatic logic [127:0] fib(input int n);
    logic [127:0] a, b, t;
    a = 0; b = 1;
    for (int i = 0; i < n; i++) begin t = a + b; a = b; b = t; end
    return a;
  endfunction

  function automatic logic [63:0] trunc(input logic [127:0] v, input int bits);
    logic [127:0] m;
    m = (128'd1 << bits) - 128'd1;
    return 64'(v & m);
  endfunction

  function automatic bit overflows(input logic [127:0] v, input int bits);
    return (v >> bits) != 0;
  endfunction

  // ---------------- behavioural engine ----------------
  int          eng_bits  = 64;
  int          clr_delay = 0;
  logic [OW-1:0] eng_res;
  logic        eng_ovf, eng_done, eng_busy;
  logic [IW-1:0] eng_n;
  int          eng_cnt, eng_clr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_res <= '0; eng_ovf <= 1'b0; eng_done <= 1'b0; eng_busy <= 1'b0;
      eng_n <= '0; eng_cnt <= 0; eng_clr <= 0;
    end else if (fib_go) begin
      eng_n    <= fib_n;
      eng_busy <= 1'b1;
      eng_cnt  <= int'(fib_n) / 8 + 1;
      eng_clr  <= clr_delay;
      if (clr_delay == 0) eng_done <= 1'b0;
    end else if (eng_clr > 0) begin
      eng_clr <= eng_clr - 1;
      if (eng_clr == 1) eng_done <= 1'b0;
    end else if (eng_busy) begin
      if (eng_cnt > 0) eng_cnt <= eng_cnt - 1;
      else begin
        eng_busy <= 1'b0;
        eng_done <= 1'b1;
        eng_res  <= trunc(fib(int'(eng_n)), eng_bits);
        if (overflows(fib(int'(eng_n)), eng_bits)) eng_ovf <= 1'b1;
      end
    end
  end

  assign fib_result   = eng_res;
  assign fib_overflow = eng_ovf;
  assign fib_done     = eng_done;

  // ---------------- scoreboard state ----------------
  int            total = 0, passed = 0;
  int            go_count = 0, resp_count = 0, hs_since_rst = 0;
  logic [IW-1:0] exp_q[$];
  bit            m_sticky = 0;
  bit            prev_hold = 0;
  logic [IW-1:0] p_n, last_n;
  logic [OW-1:0] p_res, last_res;
  logic          p_ovf, last_ovf;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Observe the current cycle (inputs already driven), then advance one clock.
  task automatic tick();
    logic [IW-1:0]  en;
    logic [127:0]   v;
    bit             big;
    #1;
    if (!rst) begin
      if (prev_hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_stable", {out_n, out_result, out_overflow}, {p_n, p_res, p_ovf});
      end
      prev_hold = out_valid && !out_ready;
      p_n = out_n; p_res = out_result; p_ovf = out_overflow;
      if (out_valid && out_ready) begin
        resp_count++; hs_since_rst++;
        last_n = out_n; last_res = out_result; last_ovf = out_overflow;
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_resp: out_n=%0d out_result=%0d with none outstanding", out_n, out_result);
        end else begin
          en  = exp_q.pop_front();
          v   = fib(int'(en));
          big = overflows(v, eng_bits);
          check("model_n", out_n, en);
          check("model_result", out_result, trunc(v, eng_bits));
          check("model_ovf", out_overflow, big && !m_sticky);
          if (big) m_sticky = 1;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(in_n);
      if (fib_go) go_count++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [IW-1:0] n, output bit ok);
    bit acc;
    ok = 0; in_valid = 1'b1; in_n = n;
    for (int i = 0; i < 40 && !ok; i++) begin acc = in_ready; tick(); ok = acc; end
    in_valid = 1'b0;
  endtask

  task automatic wait_resp(input int target);
    for (int i = 0; i < 400 && resp_count < target; i++) tick();
    check("resp_timeout", resp_count >= target, 1);
  endtask

  task automatic run_one(input logic [IW-1:0] n, input logic [63:0] res, input logic ovf);
    bit ok;
    int t;
    out_ready = 1'b1;
    t = resp_count + 1;
    push(n, ok);
    check("push_accept", ok, 1);
    wait_resp(t);
    check("seq_n", last_n, n);
    check("seq_result", last_res, res);
    check("seq_ovf", last_ovf, ovf);
  endtask

  task automatic check_reset_vals();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_n", out_n, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_overflow", out_overflow, 0);
    check("rst_fib_go", fib_go, 0);
    check("rst_fib_n", fib_n, 0);
`ifdef FIB_DISPATCH_COUNT_EN
    check("rst_job_count", job_count, 0);
`endif
  endtask

  typedef struct {
    logic [IW-1:0] n;
    logic [63:0]   res;
    logic          ovf;
  } vec_t;

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vecs[7];
    int   g0, acc, t;
    bit   ok;
    logic [63:0] burst_exp[5];
    logic [63:0] burst_got[$];

    vecs[0] = '{6'd10, 64'd55, 1'b0};
    vecs[1] = '{6'd0,  64'd0, 1'b0};
    vecs[2] = '{6'd1,  64'd1, 1'b0};
    vecs[3] = '{6'd2,  64'd1, 1'b0};
    vecs[4] = '{6'd20, 64'd6765, 1'b0};
    vecs[5] = '{6'd50, 64'd12586269025, 1'b0};
    vecs[6] = '{6'd63, 64'd6557470319842, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    repeat (2) tick();

    // Single request: exactly one fib_go pulse
    g0 = go_count;
    run_one(6'd10, 64'd55, 1'b0);
    repeat (5) tick();
    check("single_go_once", go_count - g0, 1);

    // Table-driven vectors
    foreach (vecs[i]) run_one(vecs[i].n, vecs[i].res, vecs[i].ovf);

    // Burst with consumer stalled: 1 in flight + DEPTH queued, then full
    out_ready = 1'b0;
    acc = 0;
    t = resp_count;
    burst_exp = '{64'd0, 64'd1, 64'd1, 64'd6765, 64'd2};
    begin
      logic [IW-1:0] bl[6];
      bl = '{6'd0, 6'd1, 6'd2, 6'd20, 6'd3, 6'd4};
      for (int i = 0; i < 6; i++) begin
        push(bl[i], ok);
        if (ok) acc++;
      end
    end
    check("burst_accepted", acc, DEPTH + 1);
    check("burst_full_in_ready", in_ready, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_resp(t + i + 1);
      burst_got.push_back(last_res);
    end
    for (int i = 0; i < 5; i++) check("burst_order", burst_got[i], burst_exp[i]);

    // Backpressure: response held, no new issue until handshake
    out_ready = 1'b0;
    t = resp_count;
    push(6'd7, ok);
    for (int i = 0; i < 100 && !out_valid; i++) tick();
    check("bp_valid", out_valid, 1);
    push(6'd9, ok);
    g0 = go_count;
    for (int i = 0; i < 20; i++) begin
      check("bp_valid_hold", out_valid, 1);
      check("bp_result", out_result, 13);
      tick();
    end
    check("bp_no_go", go_count - g0, 0);
    out_ready = 1'b1;
    wait_resp(t + 2);
    check("bp_second", last_res, 34);

    // Overflow reporting with an 8-bit engine
    eng_bits = 8;
    run_one(6'd13, 64'd233, 1'b0);
    run_one(6'd14, 64'd121, 1'b1);
    run_one(6'd5,  64'd5,   1'b0);
    eng_bits = 64;

    // Reset during WAIT_DONE discards queued and in-flight jobs
    out_ready = 1'b1;
    g0 = go_count;
    push(6'd30, ok);
    push(6'd31, ok);
    for (int i = 0; i < 50 && go_count == g0; i++) tick();
    check("midrst_go_seen", go_count > g0, 1);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check_reset_vals();
    tick(); tick();
    exp_q.delete();
    m_sticky = 0; prev_hold = 0; hs_since_rst = 0;
    rst = 1'b0;
    t = resp_count;
    repeat (40) tick();
    check("midrst_no_resp", resp_count - t, 0);
    run_one(6'd3, 64'd2, 1'b0);
    run_one(6'd4, 64'd3, 1'b0);
    run_one(6'd6, 64'd8, 1'b0);
`ifdef FIB_DISPATCH_COUNT_EN
    check("job_count_3", job_count, 3);
`endif

    // Randomised traffic against the reference model, 32-bit engine
    eng_bits = 32;
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_n      = IW'($urandom_range(0, 63));
      out_ready = ($urandom_range(0, 3) != 0);
      clr_delay = $urandom_range(0, 2);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 1000 && (exp_q.size() != 0 || out_valid); i++) tick();
    check("rand_drained", exp_q.size(), 0);
`ifdef FIB_DISPATCH_COUNT_EN
    check("job_count_total", job_count, hs_since_rst[15:0]);
`endif

    // Final reset
    rst = 1'b1;
    tick(); tick();
    check_reset_vals();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
